// File: rtl/nbcac_pkg.sv
// Shared NBCAC constants: codeword/data widths, drop counter width and the
// default receive FIFO depth.
package nbcac_pkg;

  localparam int unsigned NBCAC_DATA_W        = 19;
  localparam int unsigned NBCAC_CODE_W        = 27;
  localparam int unsigned NBCAC_DROP_CNT_W    = 8;
  localparam int unsigned NBCAC_RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/nbcac_rx_fifo_mem.sv
// Storage array for the NBCAC receive FIFO: one synchronous write port and
// one asynchronous read port, no reset.
module nbcac_rx_fifo_mem #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nbcac_rx_fifo.sv
// Receive elastic buffer behind the NBCAC decoder: drops and flags words that
// arrive while full. Optional drop counter enabled by NBCAC_RX_DROP_CNT_EN.
module nbcac_rx_fifo
  import nbcac_pkg::*;
#(
  parameter int unsigned DATA_W = NBCAC_DATA_W,
  parameter int unsigned DEPTH  = NBCAC_RX_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
`ifdef NBCAC_RX_DROP_CNT_EN
  output logic [NBCAC_DROP_CNT_W-1:0] drop_count,
`endif
  input  logic                       clear_ovf
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push, drop;
  logic [DATA_W-1:0] rd_data;

  nbcac_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    pop      = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push     = in_valid & (~full | pop);
    drop     = in_valid & ~push;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef NBCAC_RX_DROP_CNT_EN
  logic [NBCAC_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      drop_cnt_d = drop ? NBCAC_DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + NBCAC_DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? rd_data : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nbcac_rx_fifo.sv
// Directed self-checking bench for nbcac_rx_fifo (DEPTH=4, DATA_W=19).
module tb_nbcac_rx_fifo;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned DEPTH  = 4;

  logic              clock;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic              overflow;
  logic              clear_ovf;
`ifdef NBCAC_RX_DROP_CNT_EN
  logic [7:0]        drop_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  nbcac_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .overflow   (overflow),
`ifdef NBCAC_RX_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .clear_ovf  (clear_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_seq [4];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_level", 32'(level),     32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
`ifdef NBCAC_RX_DROP_CNT_EN
    check("rst_dcnt",  32'(drop_count), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Fill: one cycle latency on the first word
    push_word(19'h00001);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data",  32'(out_data),  32'h00001);
    push_word(19'h00002);
    push_word(19'h00003);
    push_word(19'h00004);
    check("full_level", 32'(level),     32'd4);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_head",  32'(out_data),  32'h00001);

    // Overflow while full and stalled
    push_word(19'h7FFFF);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_level", 32'(level),    32'd4);
    check("ovf_head",  32'(out_data), 32'h00001);
`ifdef NBCAC_RX_DROP_CNT_EN
    check("ovf_dcnt",  32'(drop_count), 32'd1);
`endif
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
`ifdef NBCAC_RX_DROP_CNT_EN
    check("dcnt_clr", 32'(drop_count), 32'd0);
`endif

    // Drain in order; dropped word must not appear
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'd0);
    check("drain_level", 32'(level),     32'd0);

    // Full with simultaneous push and pop
    push_word(19'h00011);
    push_word(19'h00022);
    push_word(19'h00033);
    push_word(19'h00044);
    in_valid  = 1'b1;
    in_data   = 19'h12345;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_level", 32'(level),    32'd4);
    check("pp_ovf",   32'(overflow), 32'd0);
    exp_seq[0] = 19'h00022;
    exp_seq[1] = 19'h00033;
    exp_seq[2] = 19'h00044;
    exp_seq[3] = 19'h12345;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(out_data), 32'(exp_seq[i]));
      tick();
    end
    check("pp_empty", 32'(out_valid), 32'd0);

    // Empty with simultaneous push and ready: no bypass
    in_valid = 1'b1;
    in_data  = 19'h0ABCD;
    check("byp_valid0", 32'(out_valid), 32'd0);
    check("byp_data0",  32'(out_data),  32'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("byp_valid1", 32'(out_valid), 32'd1);
    check("byp_data1",  32'(out_data),  32'h0ABCD);
    check("byp_level",  32'(level),     32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("byp_popped", 32'(level), 32'd0);

    // Set beats clear when a drop coincides with clear_ovf
    push_word(19'h00101);
    push_word(19'h00202);
    push_word(19'h00303);
    push_word(19'h00404);
    push_word(19'h00505);
    check("ovf2_set", 32'(overflow), 32'd1);
    in_valid  = 1'b1;
    in_data   = 19'h00606;
    clear_ovf = 1'b1;
    tick();
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
`ifdef NBCAC_RX_DROP_CNT_EN
    check("dcnt_clr_drop", 32'(drop_count), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    check("dcnt_sat", 32'(drop_count), 32'd255);
    in_valid  = 1'b1;
    clear_ovf = 1'b1;
    tick();
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
    check("dcnt_sat_clr", 32'(drop_count), 32'd1);
    check("dcnt_sat_ovf", 32'(overflow),   32'd1);
`endif
    check("ovf2_head", 32'(out_data), 32'h00101);

    // Reset mid-operation at level 3
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_level", 32'(level),     32'd0);
    check("mrst_ovf",   32'(overflow),  32'd0);
    check("mrst_data",  32'(out_data),  32'd0);
    in_valid = 1'b1;
    in_data  = 19'h00666;
    tick();
    check("mrst_ignore", 32'(level), 32'd0);
    rst = 1'b0;
    push_word(19'h00055);
    check("post_rst_level", 32'(level),    32'd1);
    check("post_rst_data",  32'(out_data), 32'h00055);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
